// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit driving the ALU_System datapath.
// Each instruction fetches two bytes into IR, then runs one or two execute cycles.
module control_sequencer #(
   parameter int unsigned INIT_CYCLES = 1
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] IR_In,
   input  logic [3:0]  ALU_Flag,
   output logic [2:0]  RF_OutASel,
   output logic [2:0]  RF_OutBSel,
   output logic [1:0]  RF_FunSel,
   output logic [1:0]  ARF_FunSel,
   output logic [1:0]  IR_Funsel,
   output logic [3:0]  RF_RSel,
   output logic [3:0]  RF_TSel,
   output logic [3:0]  ALU_FunSel,
   output logic [1:0]  ARF_OutCSel,
   output logic [1:0]  ARF_OutDSel,
   output logic [3:0]  ARF_RegSel,
   output logic        IR_LH,
   output logic        IR_Enable,
   output logic        Mem_WR,
   output logic        Mem_CS,
   output logic [1:0]  MuxASel,
   output logic [1:0]  MuxBSel,
   output logic        MuxCSel,
   output logic        Halted,
   output logic [2:0]  SC
);

   typedef enum logic [2:0] {
      S_INIT = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_HALT = 3'd7
   } state_t;

   localparam logic [3:0] OP_LDI = 4'h0;
   localparam logic [3:0] OP_LD  = 4'h1;
   localparam logic [3:0] OP_ST  = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_BRA = 4'h6;
   localparam logic [3:0] OP_BNE = 4'h7;
   localparam logic [3:0] OP_INC = 4'h8;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] INIT_LAST = 2'(INIT_CYCLES - 1);

   state_t     r_state;
   logic [1:0] r_init_cnt;
   logic       r_zflag;

   logic [3:0] w_opcode;
   logic [1:0] w_rx;
   logic [1:0] w_ry;
   logic [3:0] w_rx_onehot;
   logic       w_unused;

   function automatic logic [3:0] reg_onehot(input logic [1:0] n);
      logic [3:0] oh;
      case (n)
         2'd0:    oh = 4'b1000;
         2'd1:    oh = 4'b0100;
         2'd2:    oh = 4'b0010;
         2'd3:    oh = 4'b0001;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

   assign w_opcode    = IR_In[15:12];
   assign w_rx        = IR_In[11:10];
   assign w_ry        = IR_In[9:8];
   assign w_rx_onehot = reg_onehot(w_rx);
   // The immediate field and C/N/O flags are consumed by the datapath, not here.
   assign w_unused    = ^{IR_In[7:0], ALU_Flag[2:0]};

   // State sequencing, init counting and the zero flag latched by ALU ops.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_state    <= S_INIT;
         r_init_cnt <= 2'd0;
         r_zflag    <= 1'b0;
      end else begin
         case (r_state)
            S_INIT: begin
               if (r_init_cnt == INIT_LAST) begin
                  r_state    <= S_T0;
                  r_init_cnt <= 2'd0;
               end else begin
                  r_init_cnt <= r_init_cnt + 2'd1;
               end
            end
            S_T0: r_state <= S_T1;
            S_T1: r_state <= S_T2;
            S_T2: begin
               case (w_opcode)
                  OP_LD, OP_ST: r_state <= S_T3;
                  OP_ADD, OP_SUB, OP_AND: begin
                     r_zflag <= ALU_Flag[3];
                     r_state <= S_T0;
                  end
                  OP_HLT:  r_state <= S_HALT;
                  default: r_state <= S_T0;
               endcase
            end
            S_T3:    r_state <= S_T0;
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_INIT;
         endcase
      end
   end

   // Control word decode from state, instruction and stored zero flag.
   always_comb begin
      RF_OutASel  = 3'b000;
      RF_OutBSel  = 3'b000;
      RF_FunSel   = 2'b00;
      ARF_FunSel  = 2'b00;
      IR_Funsel   = 2'b00;
      RF_RSel     = 4'b0000;
      RF_TSel     = 4'b0000;
      ALU_FunSel  = 4'b0000;
      ARF_OutCSel = 2'b00;
      ARF_OutDSel = 2'b00;
      ARF_RegSel  = 4'b0000;
      IR_LH       = 1'b0;
      IR_Enable   = 1'b0;
      Mem_WR      = 1'b0;
      Mem_CS      = 1'b1;
      MuxASel     = 2'b00;
      MuxBSel     = 2'b00;
      MuxCSel     = 1'b0;
      Halted      = 1'b0;
      SC          = r_state;
      case (r_state)
         S_INIT: begin
            RF_FunSel  = 2'b11;
            RF_RSel    = 4'b1111;
            RF_TSel    = 4'b1111;
            ARF_FunSel = 2'b11;
            ARF_RegSel = 4'b1110;
            IR_Enable  = 1'b1;
            IR_Funsel  = 2'b11;
         end
         S_T0, S_T1: begin
            Mem_CS     = 1'b0;
            IR_Enable  = 1'b1;
            IR_Funsel  = 2'b10;
            IR_LH      = (r_state == S_T1);
            ARF_RegSel = 4'b1000;
            ARF_FunSel = 2'b01;
         end
         S_T2: begin
            case (w_opcode)
               OP_LDI: begin
                  MuxASel   = 2'b10;
                  RF_FunSel = 2'b10;
                  RF_RSel   = w_rx_onehot;
               end
               OP_LD, OP_ST: begin
                  MuxBSel    = 2'b10;
                  ARF_FunSel = 2'b10;
                  ARF_RegSel = 4'b0100;
               end
               OP_ADD, OP_SUB, OP_AND: begin
                  RF_OutASel = {1'b1, w_rx};
                  RF_OutBSel = {1'b1, w_ry};
                  MuxCSel    = 1'b1;
                  MuxASel    = 2'b00;
                  RF_FunSel  = 2'b10;
                  RF_RSel    = w_rx_onehot;
                  if (w_opcode == OP_ADD) begin
                     ALU_FunSel = 4'b0100;
                  end else if (w_opcode == OP_SUB) begin
                     ALU_FunSel = 4'b0110;
                  end else begin
                     ALU_FunSel = 4'b0111;
                  end
               end
               OP_BRA: begin
                  MuxBSel    = 2'b10;
                  ARF_FunSel = 2'b10;
                  ARF_RegSel = 4'b1000;
               end
               OP_BNE: begin
                  if (!r_zflag) begin
                     MuxBSel    = 2'b10;
                     ARF_FunSel = 2'b10;
                     ARF_RegSel = 4'b1000;
                  end else begin
                     MuxBSel = 2'b00;
                  end
               end
               OP_INC: begin
                  RF_FunSel = 2'b01;
                  RF_RSel   = w_rx_onehot;
               end
               default: begin
                  Mem_CS = 1'b1;
               end
            endcase
         end
         S_T3: begin
            ARF_OutDSel = 2'b01;
            Mem_CS      = 1'b0;
            if (w_opcode == OP_ST) begin
               RF_OutASel = {1'b1, w_rx};
               MuxCSel    = 1'b1;
               ALU_FunSel = 4'b0000;
               Mem_WR     = 1'b1;
            end else begin
               MuxASel   = 2'b01;
               RF_FunSel = 2'b10;
               RF_RSel   = w_rx_onehot;
            end
         end
         S_HALT: begin
            Halted = 1'b1;
         end
         default: begin
            SC = r_state;
         end
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset/init, fetch, each instruction class,
// branch on zero flag, halt hold, and reset landing in the middle of a store.
module tb_control_sequencer;

   logic        Clock;
   logic        Reset;
   logic [15:0] IR_In;
   logic [3:0]  ALU_Flag;
   logic [2:0]  RF_OutASel, RF_OutBSel;
   logic [1:0]  RF_FunSel, ARF_FunSel, IR_Funsel;
   logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
   logic [1:0]  ARF_OutCSel, ARF_OutDSel;
   logic [3:0]  ARF_RegSel;
   logic        IR_LH, IR_Enable, Mem_WR, Mem_CS;
   logic [1:0]  MuxASel, MuxBSel;
   logic        MuxCSel, Halted;
   logic [2:0]  SC;

   int n_pass  = 0;
   int n_total = 0;

   control_sequencer #(.INIT_CYCLES(1)) dut (
      .Clock(Clock), .Reset(Reset), .IR_In(IR_In), .ALU_Flag(ALU_Flag),
      .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel),
      .RF_FunSel(RF_FunSel), .ARF_FunSel(ARF_FunSel), .IR_Funsel(IR_Funsel),
      .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
      .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_RegSel(ARF_RegSel),
      .IR_LH(IR_LH), .IR_Enable(IR_Enable), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
      .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
      .Halted(Halted), .SC(SC)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      Reset    = 1'b0;
      IR_In    = 16'h0000;
      ALU_Flag = 4'b0000;
      tick();
      tick();
      chk("reset_sc", 16'(SC), 16'd0);
      Reset = 1'b1;
      chk("init_sc", 16'(SC), 16'd0);
      chk("init_rsel", 16'(RF_RSel), 16'hF);
      chk("init_tsel", 16'(RF_TSel), 16'hF);
      chk("init_arfreg", 16'(ARF_RegSel), 16'hE);
      chk("init_irfun", 16'(IR_Funsel), 16'h3);
      chk("init_cs", 16'(Mem_CS), 16'd1);

      // ADD R2,R3
      tick();
      chk("t0_sc", 16'(SC), 16'd1);
      chk("t0_cs", 16'(Mem_CS), 16'd0);
      chk("t0_iren", 16'(IR_Enable), 16'd1);
      chk("t0_lh", 16'(IR_LH), 16'd0);
      chk("t0_arfreg", 16'(ARF_RegSel), 16'h8);
      chk("t0_arffun", 16'(ARF_FunSel), 16'h1);
      IR_In = 16'h3600;
      tick();
      chk("t1_sc", 16'(SC), 16'd2);
      chk("t1_lh", 16'(IR_LH), 16'd1);
      tick();
      chk("add_sc", 16'(SC), 16'd3);
      chk("add_osa", 16'(RF_OutASel), 16'h5);
      chk("add_osb", 16'(RF_OutBSel), 16'h6);
      chk("add_alu", 16'(ALU_FunSel), 16'h4);
      chk("add_muxc", 16'(MuxCSel), 16'd1);
      chk("add_rsel", 16'(RF_RSel), 16'h4);
      chk("add_rffun", 16'(RF_FunSel), 16'h2);
      tick();
      chk("add_next", 16'(SC), 16'd1);

      // LD R3
      IR_In = 16'h1842;
      tick(); tick();
      chk("ld_t2_arfreg", 16'(ARF_RegSel), 16'h4);
      chk("ld_t2_arffun", 16'(ARF_FunSel), 16'h2);
      chk("ld_t2_muxb", 16'(MuxBSel), 16'h2);
      tick();
      chk("ld_t3_sc", 16'(SC), 16'd4);
      chk("ld_t3_outd", 16'(ARF_OutDSel), 16'h1);
      chk("ld_t3_cs", 16'(Mem_CS), 16'd0);
      chk("ld_t3_wr", 16'(Mem_WR), 16'd0);
      chk("ld_t3_muxa", 16'(MuxASel), 16'h1);
      chk("ld_t3_rsel", 16'(RF_RSel), 16'h2);
      tick();
      chk("ld_next", 16'(SC), 16'd1);

      // SUB with Z=1, then BNE must not branch
      IR_In = 16'h4100; ALU_Flag = 4'b1000;
      tick(); tick();
      chk("sub_alu", 16'(ALU_FunSel), 16'h6);
      tick();
      ALU_Flag = 4'b0000;
      IR_In = 16'h7012;
      tick(); tick();
      chk("bne_z1_arfreg", 16'(ARF_RegSel), 16'h0);
      chk("bne_z1_muxb", 16'(MuxBSel), 16'h0);
      tick();

      // SUB with Z=0, then BNE branches
      IR_In = 16'h4100;
      tick(); tick(); tick();
      IR_In = 16'h7012;
      tick(); tick();
      chk("bne_z0_arfreg", 16'(ARF_RegSel), 16'h8);
      chk("bne_z0_muxb", 16'(MuxBSel), 16'h2);
      chk("bne_z0_arffun", 16'(ARF_FunSel), 16'h2);
      tick();

      // LDI R4
      IR_In = 16'h0C55;
      tick(); tick();
      chk("ldi_muxa", 16'(MuxASel), 16'h2);
      chk("ldi_rffun", 16'(RF_FunSel), 16'h2);
      chk("ldi_rsel", 16'(RF_RSel), 16'h1);
      tick();
      chk("ldi_next", 16'(SC), 16'd1);

      // HLT and hold
      IR_In = 16'hF000;
      tick(); tick();
      chk("hlt_t2_cs", 16'(Mem_CS), 16'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("halt_sc", 16'(SC), 16'd7);
         chk("halt_flag", 16'(Halted), 16'd1);
         chk("halt_idle", {Mem_WR, Mem_CS, ARF_RegSel, RF_RSel, IR_Enable, 5'b0},
             {1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 5'b0});
      end
      Reset = 1'b0;
      tick();
      chk("halt_reset_sc", 16'(SC), 16'd0);
      chk("halt_reset_halted", 16'(Halted), 16'd0);
      Reset = 1'b1;
      tick();
      chk("rst_to_t0", 16'(SC), 16'd1);

      // ST interrupted by reset during T2
      IR_In = 16'h2C10;
      tick(); tick();
      chk("st_t2_sc", 16'(SC), 16'd3);
      chk("st_t2_arfreg", 16'(ARF_RegSel), 16'h4);
      Reset = 1'b0;
      tick();
      chk("st_rst_sc", 16'(SC), 16'd0);
      chk("st_rst_wr", 16'(Mem_WR), 16'd0);
      chk("st_rst_cs", 16'(Mem_CS), 16'd1);
      Reset = 1'b1;
      tick(); tick(); tick(); tick();
      chk("st_t3_sc", 16'(SC), 16'd4);
      chk("st_t3_wr", 16'(Mem_WR), 16'd1);
      chk("st_t3_cs", 16'(Mem_CS), 16'd0);
      chk("st_t3_osa", 16'(RF_OutASel), 16'h7);
      chk("st_t3_muxc", 16'(MuxCSel), 16'd1);
      chk("st_t3_outd", 16'(ARF_OutDSel), 16'h1);
      tick();
      chk("st_next", 16'(SC), 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
